// File: rtl/mem_rr_arb_if.sv
// mem_rr_arb_if: requester-side and memory-side bus of the shared memory port.
//
// Handshake (valid/ready, both sides): a requester raises m_valid[i] with its
// addr/wdata/wstrb and holds all of them stable until the cycle in which
// m_ready[i] is high; that cycle completes the transaction and m_rdata carries
// the read data. Downstream, mem_valid/mem_addr/mem_wdata/mem_wstrb stay stable
// until mem_ready, and mem_rdata is valid in the mem_ready cycle. wstrb == 0
// means a read.
//
// Signals:
//   m_valid/m_ready   per-requester request / completion pulse (NPORTS bits)
//   m_addr/m_wdata    32 bits per requester, port i at [32i+31:32i]
//   m_wstrb           4 bits per requester, port i at [4i+3:4i]
//   m_rdata           read data broadcast to all requesters
//   mem_*             single downstream memory port
// Modports:
//   master  the arbiter (issues the downstream request)
//   slave   the environment (requesters plus memory)
interface mem_rr_arb_if #(
  parameter int NPORTS = 3
) ();
  logic [NPORTS-1:0]    m_valid;
  logic [NPORTS-1:0]    m_ready;
  logic [32*NPORTS-1:0] m_addr;
  logic [32*NPORTS-1:0] m_wdata;
  logic [4*NPORTS-1:0]  m_wstrb;
  logic [31:0]          m_rdata;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic [31:0]          mem_rdata;

  modport master (
    input  m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata,
    output m_ready, m_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata,
    input  m_ready, m_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_rr_arb.sv
// mem_rr_arb: round-robin arbiter/sequencer sharing one memory port between
// NPORTS requesters. An IDLE cycle registers a one-hot grant, the BUSY state
// passes exactly one transaction through combinationally, and priority rotates
// to start after the port that last completed. A watchdog sets a sticky fault
// when a BUSY transaction sees no mem_ready for TIMEOUT cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        mem_rr_arb_if.master (requester and memory handshakes)
//   gnt        one-hot current grant, zero when not BUSY
//   fault      sticky watchdog fault, cleared only by rst
//   dbg_state  FSM state (0 = IDLE, 1 = BUSY)
module mem_rr_arb #(
  parameter int NPORTS  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_rr_arb_if.master       bus,
  output logic [NPORTS-1:0]  gnt,
  output logic               fault,
  output logic               dbg_state
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   g_idx;
  logic [15:0]     wdog;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            sel_valid;

  // Search last+1, last+2, ... (mod NPORTS); the first requester found wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand = IW'((int'(last) + k) % NPORTS);
      if (!pick_valid && bus.m_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // gnt is zero outside BUSY, so masking with it also gates everything to IDLE.
  assign sel_valid = |(gnt & bus.m_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      g_idx <= '0;
      last  <= IW'(NPORTS - 1);
      wdog  <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fault && pick_valid) begin
            gnt   <= NPORTS'(1) << pick_idx;
            g_idx <= pick_idx;
            wdog  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            // Completion beats a same-cycle watchdog expiry.
            state <= IDLE;
            gnt   <= '0;
            last  <= g_idx;
          end else if (!sel_valid) begin
            // Requester withdrew: drop the grant, keep the rotation point.
            state <= IDLE;
            gnt   <= '0;
          end else if (wdog == WDOG_LIMIT) begin
            fault <= 1'b1;
            state <= IDLE;
            gnt   <= '0;
          end else if (wdog != 16'hffff) begin
            wdog <= wdog + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // Downstream pass-through of the granted port; all zero when nothing is granted.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gnt[i]) begin
        bus.mem_addr  = bus.m_addr[i*32 +: 32];
        bus.mem_wdata = bus.m_wdata[i*32 +: 32];
        bus.mem_wstrb = bus.m_wstrb[i*4 +: 4];
      end
    end
  end

  assign bus.mem_valid = sel_valid & ~fault;
  assign bus.m_ready   = gnt & {NPORTS{bus.mem_ready}};
  assign bus.m_rdata   = bus.mem_rdata;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_rr_arb.sv
// tb_mem_rr_arb: directed bench for mem_rr_arb with NPORTS=3, TIMEOUT=4.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_rr_arb;
  localparam int NPORTS  = 3;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NPORTS-1:0] gnt;
  logic              fault;
  logic              dbg_state;

  int errors = 0;
  int checks = 0;

  mem_rr_arb_if #(.NPORTS(NPORTS)) bus ();

  mem_rr_arb #(.NPORTS(NPORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .gnt       (gnt),
    .fault     (fault),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    bus.m_valid   = '0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.m_wstrb   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    case (p)
      0: begin bus.m_addr[31:0]  = a; bus.m_wdata[31:0]  = d; bus.m_wstrb[3:0]  = s; end
      1: begin bus.m_addr[63:32] = a; bus.m_wdata[63:32] = d; bus.m_wstrb[7:4]  = s; end
      default: begin bus.m_addr[95:64] = a; bus.m_wdata[95:64] = d; bus.m_wstrb[11:8] = s; end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", bus.mem_valid); end
    checks++; if (bus.m_ready !== 3'b000) begin errors++; $display("FAIL reset_m_ready: got %b expected 000", bus.m_ready); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_mem_wstrb: got %h expected 0", bus.mem_wstrb); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    set_port(1, 32'h100, 32'h0, 4'h0);
    bus.m_valid = 3'b010;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL read_gnt: got %b expected 010", gnt); end
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL read_state: got %b expected 1", dbg_state); end
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL read_mem_valid: got %b expected 1", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL read_mem_addr: got %h expected 100", bus.mem_addr); end
    checks++; if (bus.mem_wstrb !== 4'h0) begin errors++; $display("FAIL read_mem_wstrb: got %h expected 0", bus.mem_wstrb); end
    checks++; if (bus.m_ready !== 3'b000) begin errors++; $display("FAIL read_no_ready_c1: got %b expected 000", bus.m_ready); end
    @(negedge clk); #1;
    checks++; if (bus.m_ready !== 3'b000) begin errors++; $display("FAIL read_no_ready_c2: got %b expected 000", bus.m_ready); end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.m_ready !== 3'b010) begin errors++; $display("FAIL read_m_ready: got %b expected 010", bus.m_ready); end
    checks++; if (bus.m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m_rdata: got %h expected deadbeef", bus.m_rdata); end
    // Requester withdraws; mem_ready left high must be ignored in IDLE.
    @(negedge clk);
    bus.m_valid = 3'b000;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL read_gnt_after: got %b expected 000", gnt); end
    checks++; if (bus.m_ready !== 3'b000) begin errors++; $display("FAIL read_ready_pulse: got %b expected 000", bus.m_ready); end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL read_idle_stays: got %b expected 0", dbg_state); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g;
    logic [31:0] exp_a;
    do_reset();
    for (int p = 0; p < 3; p++) set_port(p, 32'h1000 + 32'(p) * 32'h10, 32'h0, 4'h0);
    bus.m_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      exp_g = 3'b001 << (t % 3);
      exp_a = 32'h1000 + 32'(t % 3) * 32'h10;
      @(negedge clk); #1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", t, gnt, exp_g); end
      checks++; if (bus.mem_addr !== exp_a) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", t, bus.mem_addr, exp_a); end
      bus.mem_ready = 1'b1;
      #1;
      checks++; if (bus.m_ready !== exp_g) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", t, bus.m_ready, exp_g); end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      checks++; if (gnt !== 3'b000 || dbg_state !== 1'b0) begin errors++; $display("FAIL rr_idle_gap[%0d]: got gnt=%b state=%b expected 000/0", t, gnt, dbg_state); end
    end
    bus.m_valid = 3'b000;
  endtask

  task automatic test_write_pass();
    do_reset();
    set_port(2, 32'h2000_0004, 32'h12345678, 4'b0011);
    bus.m_valid = 3'b100;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL wr_gnt[%0d]: got %b expected 100", c, gnt); end
      checks++; if (bus.mem_addr !== 32'h2000_0004) begin errors++; $display("FAIL wr_addr[%0d]: got %h expected 20000004", c, bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata[%0d]: got %h expected 12345678", c, bus.mem_wdata); end
      checks++; if (bus.mem_wstrb !== 4'b0011) begin errors++; $display("FAIL wr_wstrb[%0d]: got %b expected 0011", c, bus.mem_wstrb); end
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.m_ready !== 3'b100) begin errors++; $display("FAIL wr_ready: got %b expected 100", bus.m_ready); end
    @(negedge clk);
    bus.m_valid = 3'b000;
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0) begin
      errors++; $display("FAIL wr_idle_zero: got addr=%h wdata=%h wstrb=%h expected 0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
  endtask

  task automatic test_late_arrival();
    do_reset();
    set_port(0, 32'hA0, 32'h0, 4'h0);
    set_port(1, 32'hB0, 32'h0, 4'h0);
    bus.m_valid = 3'b010;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL late_gnt1: got %b expected 010", gnt); end
    bus.m_valid = 3'b011;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL late_no_preempt: got %b expected 010", gnt); end
    checks++; if (bus.mem_addr !== 32'hB0) begin errors++; $display("FAIL late_addr1: got %h expected b0", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.m_ready !== 3'b010) begin errors++; $display("FAIL late_ready1: got %b expected 010", bus.m_ready); end
    @(negedge clk);
    bus.m_valid = 3'b001;
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL late_idle: got %b expected 000", gnt); end
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL late_gnt0: got %b expected 001", gnt); end
    checks++; if (bus.mem_addr !== 32'hA0) begin errors++; $display("FAIL late_addr0: got %h expected a0", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.m_valid = 3'b000;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    set_port(0, 32'hC0, 32'h0, 4'h0);
    bus.m_valid = 3'b001;
    for (int b = 1; b <= TIMEOUT; b++) begin
      @(negedge clk); #1;
      checks++; if (gnt !== 3'b001 || fault !== 1'b0 || bus.mem_valid !== 1'b1) begin
        errors++; $display("FAIL wd_busy[%0d]: got gnt=%b fault=%b mem_valid=%b expected 001/0/1", b, gnt, fault, bus.mem_valid);
      end
    end
    @(negedge clk); #1;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wd_fault: got %b expected 1", fault); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL wd_mem_valid: got %b expected 0", bus.mem_valid); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL wd_gnt: got %b expected 000", gnt); end
    bus.m_valid = 3'b111;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (gnt !== 3'b000 || dbg_state !== 1'b0 || fault !== 1'b1 || bus.m_ready !== 3'b000) begin
        errors++; $display("FAIL wd_blocked[%0d]: got gnt=%b state=%b fault=%b m_ready=%b expected 000/0/1/000", c, gnt, dbg_state, fault, bus.m_ready);
      end
    end
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wd_rst_clears: got %b expected 0", fault); end
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wd_first_after_rst: got %b expected 001", gnt); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.m_valid = 3'b000;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_timeout_ready_wins();
    do_reset();
    bus.m_valid = 3'b010;
    repeat (TIMEOUT) @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.m_ready !== 3'b010) begin errors++; $display("FAIL tr_ready: got %b expected 010", bus.m_ready); end
    @(negedge clk);
    bus.m_valid = 3'b000;
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL tr_no_fault: got %b expected 0", fault); end
    bus.m_valid = 3'b001;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL tr_next_gnt: got %b expected 001", gnt); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.m_valid = 3'b000;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    bus.m_valid = 3'b010;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL ab_gnt: got %b expected 010", gnt); end
    bus.m_valid = 3'b000;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b000 || dbg_state !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL ab_idle: got gnt=%b state=%b fault=%b expected 000/0/0", gnt, dbg_state, fault);
    end
    // last still points at port 2, so port 1 beats port 2.
    bus.m_valid = 3'b110;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL ab_last_kept: got %b expected 010", gnt); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.m_valid = 3'b000;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_rst_mid_busy();
    do_reset();
    set_port(2, 32'h3000, 32'hCAFEF00D, 4'hF);
    bus.m_valid = 3'b100;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rb_gnt: got %b expected 100", gnt); end
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b000 || bus.mem_valid !== 1'b0 || bus.m_ready !== 3'b000 || fault !== 1'b0) begin
      errors++; $display("FAIL rb_ctrl_zero: got gnt=%b mem_valid=%b m_ready=%b fault=%b expected all 0", gnt, bus.mem_valid, bus.m_ready, fault);
    end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0) begin
      errors++; $display("FAIL rb_bus_zero: got addr=%h wdata=%h wstrb=%h expected 0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rb_regrant: got %b expected 100", gnt); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.m_valid = 3'b000;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish by 100us expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_pass();
    test_late_arrival();
    test_watchdog();
    test_timeout_ready_wins();
    test_abort();
    test_rst_mid_busy();
    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
